// File: rtl/shift_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_piso_tx
//   Parallel-in / serial-out transmitter. A WIDTH-bit word is captured on the
//   edge that accepts start and shifted out MSB first on sdo. Each bit is held
//   for BIT_CYCLES clocks. A one-cycle done pulse follows the last bit, and the
//   block then returns to idle.
//
// Parameters
//   WIDTH       data bits per frame (2..32)
//   BIT_CYCLES  clocks each bit is held on sdo (1..256)
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous, active-high reset
//   data_in  in   parallel word, sampled only on the accepting edge
//   start    in   transfer request, honoured only in IDLE
//   ready    out  high in IDLE (a start will be accepted)
//   sdo      out  serial data, MSB first, 0 outside a frame
//   frame    out  high while a data bit is on sdo
//   done     out  one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module shift_piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic             ready,
  output logic             sdo,
  output logic             frame,
  output logic             done
);

  // +1 keeps both counters at least one bit wide and able to hold the
  // largest value they ever reach without wrapping.
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic             sdo_q, sdo_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      sdo_q     <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      sdo_q     <= sdo_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          shreg_d   = data_in;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      SHIFT: begin
        if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state and registered, so every output
  // is a flop with no combinational path from data_in or start. sdo picks the
  // MSB of the next shift-register value, which on the accepting edge is the
  // captured word's MSB -- giving the first bit one cycle after acceptance.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    sdo_d   = 1'b0;
    unique case (state_d)
      IDLE:    ready_d = 1'b1;
      SHIFT: begin
        frame_d = 1'b1;
        sdo_d   = shreg_d[WIDTH-1];
      end
      DONE:    done_d  = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  assign ready = ready_q;
  assign sdo   = sdo_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_shift_piso_tx
//   Two instances: dut_a (WIDTH=8, BIT_CYCLES=4) and dut_b (WIDTH=8,
//   BIT_CYCLES=1). Frames are described by a table of records with the
//   hand-written expected sdo pattern; each cycle of a frame compares
//   {ready,frame,done,sdo}. Reset scenarios are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_shift_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       start_a, start_b;
  logic       ready_a, sdo_a, frame_a, done_a;
  logic       ready_b, sdo_b, frame_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_piso_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(din), .start(start_a),
    .ready(ready_a), .sdo(sdo_a), .frame(frame_a), .done(done_a)
  );

  shift_piso_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(din), .start(start_b),
    .ready(ready_b), .sdo(sdo_b), .frame(frame_b), .done(done_b)
  );

  typedef struct {
    bit         sel;     // 0: dut_a (4 cycles/bit), 1: dut_b (1 cycle/bit)
    logic [7:0] data;
    logic [7:0] exp;     // expected sdo sequence, first bit in [7]
    bit         toggle;  // invert data_in every cycle of the frame
    bit         pulse;   // raise start with data_in=FF mid-frame
    bit         hold;    // leave start high into the next frame
  } vec_t;

  vec_t vecs[7];

  // {ready, frame, done, sdo}
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {ready_b, frame_b, done_b, sdo_b}
               : {ready_a, frame_a, done_a, sdo_a};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {ready,frame,done,sdo} got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // Entry: just after a negedge with the selected DUT idle.
  // Exit: just after the negedge of the idle cycle following done.
  task automatic run_frame(input int idx, input vec_t v);
    int bc;
    bc = v.sel ? 1 : 4;
    chk($sformatf("v%0d idle", idx), outs(v.sel), 4'b1000);
    din = v.data;
    set_start(v.sel, 1'b1);
    @(posedge clk);
    #1;
    if (!v.hold) set_start(v.sel, 1'b0);
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d bit%0d cyc%0d", idx, b, c), outs(v.sel),
            {3'b010, v.exp[7-b]});
        if (v.toggle) din = ~din;
        if (v.pulse && b == 2 && c == 0) begin
          din = 8'hFF;
          set_start(v.sel, 1'b1);
        end
        if (!v.hold && b == 7 && c == bc - 1) set_start(v.sel, 1'b0);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d done", idx), outs(v.sel), 4'b0010);
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), outs(v.sel), 4'b1000);
  endtask

  initial begin
    vecs[0] = '{sel:0, data:8'hA5, exp:8'b1010_0101, toggle:0, pulse:0, hold:0};
    vecs[1] = '{sel:0, data:8'hA5, exp:8'b1010_0101, toggle:0, pulse:1, hold:0};
    vecs[2] = '{sel:0, data:8'h3C, exp:8'b0011_1100, toggle:0, pulse:0, hold:1};
    vecs[3] = '{sel:0, data:8'hC3, exp:8'b1100_0011, toggle:0, pulse:0, hold:0};
    vecs[4] = '{sel:0, data:8'h5A, exp:8'b0101_1010, toggle:1, pulse:0, hold:0};
    vecs[5] = '{sel:1, data:8'h81, exp:8'b1000_0001, toggle:0, pulse:0, hold:0};
    vecs[6] = '{sel:1, data:8'h5A, exp:8'b0101_1010, toggle:1, pulse:0, hold:0};

    rst = 1'b1;
    din = 8'h00;
    start_a = 1'b0;
    start_b = 1'b0;
    #1;
    chk("reset a", outs(0), 4'b1000);
    chk("reset b", outs(1), 4'b1000);
    // start high during reset must not launch anything
    start_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset held a", outs(0), 4'b1000);
    start_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_frame(i, vecs[i]);

    // Async reset in the middle of bit 3 of an A5 frame (bit 3 is '0').
    din = 8'hA5;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int k = 0; k < 14; k++) @(negedge clk);  // bit 3, second cycle
    chk("pre-rst bit3", outs(0), 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst mid-frame", outs(0), 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst idle %0d", k), outs(0), 4'b1000);
    end

    // Async reset landing in the DONE cycle of a BIT_CYCLES=1 frame.
    din = 8'hFF;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < 9; k++) @(negedge clk);
    chk("b in done", outs(1), 4'b0010);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst in done", outs(1), 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Normal frame straight after reset.
    run_frame(7, '{sel:0, data:8'h96, exp:8'b1001_0110, toggle:0, pulse:0, hold:0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_piso_tx.md
SHIFT_PISO_TX -- requirements
Module: shift_piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of data bits per frame; legal range 2..32.
REQ-002 The block SHALL have parameter BIT_CYCLES, default 4, clk cycles each serial bit is held on sdo; legal range 1..256.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 The block SHALL have port start  input  1  transfer request, sampled on rising edge of clk.
REQ-007 The block SHALL have port ready  output  1  high when a start will be accepted.
REQ-008 The block SHALL have port sdo  output  1  serial data out, MSB first.
REQ-009 The block SHALL have port frame  output  1  high while a data bit is being driven on sdo.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-011 The block SHALL implement a registered FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE: ready=1, frame=0, sdo=0, done=0.
REQ-013 IDLE->SHIFT on a rising edge where start=1; on that edge data_in SHALL be captured into an internal WIDTH-bit shift register, the bit counter cleared and the cycle counter cleared.
REQ-014 In SHIFT: ready=0, frame=1, sdo = current MSB of the shift register (registered output, no combinational path from data_in or start).
REQ-015 Each bit SHALL be held for exactly BIT_CYCLES cycles; after the BIT_CYCLES-th cycle the register shifts left by one (zero fill) and the bit counter increments.
REQ-016 SHIFT->DONE after bit WIDTH-1 has been held BIT_CYCLES cycles; frame SHALL therefore be high for exactly WIDTH*BIT_CYCLES consecutive cycles.
REQ-017 In DONE: done=1, frame=0, sdo=0, ready=0 for exactly one cycle; DONE->IDLE unconditionally.
REQ-018 Latency: first data bit SHALL appear on sdo the cycle immediately after the accepting edge.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing of requests.
REQ-020 Changes on data_in after the accepting edge SHALL have no effect on the frame in progress.
REQ-021 With start held high continuously, a new frame SHALL be accepted on the first edge in IDLE, giving exactly one idle cycle (ready=1) between done and the next frame.
REQ-022 Cycle counter and bit counter widths SHALL be sized from BIT_CYCLES and WIDTH so no wrap-around occurs at maximum parameter values.
REQ-023 BIT_CYCLES=1 SHALL produce one bit per clock with no dead cycles between bits.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE, shift register and counters 0, and outputs ready=1, sdo=0, frame=0, done=0.
REQ-025 Assertion of rst SHALL take effect immediately without waiting for a clk edge, including mid-frame or during DONE; the aborted frame produces no done pulse.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL begin a normal frame.

Verification
REQ-027 WIDTH=8, BIT_CYCLES=4, data_in=0xA5, one-cycle start -> sdo = 1,0,1,0,0,1,0,1 each held 4 cycles, frame high 32 cycles, done=1 on cycle 33 only, ready=1 on cycle 34.
REQ-028 Same config, start pulsed again during SHIFT with data_in=0xFF -> ignored; sdo continues the 0xA5 pattern, exactly one done pulse.
REQ-029 start held high, data_in=0x3C then 0xC3 applied at the second accept -> two frames, one ready=1 cycle between done and second frame's first bit, second frame sdo = 1,1,0,0,0,0,1,1.
REQ-030 rst asserted asynchronously during bit 3 of a 0xA5 frame -> sdo=0, frame=0, ready=1 before the next clk edge; no done pulse follows.
REQ-031 WIDTH=8, BIT_CYCLES=1, data_in=0x81 -> sdo = 1,0,0,0,0,0,0,1 on 8 consecutive cycles, done on cycle 9.
REQ-032 data_in toggled every cycle during a 0x5A frame -> sdo pattern unchanged (0,1,0,1,1,0,1,0).
